// File: rtl/pulse_gen_multi_if.sv
// pulse_gen_multi_if
// Bundles the per-channel control inputs and status outputs of the
// multi-channel pulse generator. The controller side uses the master
// modport. The generator itself uses the slave modport.
interface pulse_gen_multi_if #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic [NUM_CH-1:0]         enable;
    logic [NUM_CH-1:0]         mode;
    logic [NUM_CH-1:0]         start;
    logic [NUM_CH*CNT_W-1:0]   active_cycles;
    logic [NUM_CH*CNT_W-1:0]   non_active_cycles;
    logic [NUM_CH*BURST_W-1:0] burst_len;
    logic [NUM_CH-1:0]         pulse_gen_output;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         done;

    modport master (
        output enable,
        output mode,
        output start,
        output active_cycles,
        output non_active_cycles,
        output burst_len,
        input  pulse_gen_output,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  mode,
        input  start,
        input  active_cycles,
        input  non_active_cycles,
        input  burst_len,
        output pulse_gen_output,
        output busy,
        output done
    );
endinterface

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi
// Multi-channel programmable pulse generator. Each channel runs its own
// IDLE / ACTIVE / NON_ACTIVE state machine. A channel produces either a
// continuous pulse train or a counted burst of pulses. The high and low
// durations are counted in clock cycles, and a zero count is treated as 1.
// All outputs are decoded from registered state, so no input has a
// combinational path to an output.
module pulse_gen_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    pulse_gen_multi_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACTIVE     = 2'd1,
        NON_ACTIVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    // A programmed count of zero behaves as a count of one.
    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] value);
        return (value == '0) ? CNT_ONE : value;
    endfunction

    function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] value);
        return (value == '0) ? BURST_ONE : value;
    endfunction

    logic [NUM_CH-1:0] pulse_vec;
    logic [NUM_CH-1:0] busy_vec;
    logic [NUM_CH-1:0] done_vec;

    assign bus.pulse_gen_output = pulse_vec;
    assign bus.busy             = busy_vec;
    assign bus.done             = done_vec;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t             state;
        logic [CNT_W-1:0]   cnt;
        logic [CNT_W-1:0]   non_active_lat;
        logic [BURST_W-1:0] remaining;
        logic               burst_mode;
        logic               done_q;

        logic [CNT_W-1:0]   active_req;
        logic [CNT_W-1:0]   non_active_req;
        logic [BURST_W-1:0] burst_req;

        assign active_req     = clamp_cnt(bus.active_cycles[c*CNT_W +: CNT_W]);
        assign non_active_req = clamp_cnt(bus.non_active_cycles[c*CNT_W +: CNT_W]);
        assign burst_req      = clamp_burst(bus.burst_len[c*BURST_W +: BURST_W]);

        // The counter holds the remaining cycles of the current phase minus one.
        // Remaining holds the pulses still to start after the current one.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state          <= IDLE;
                cnt            <= '0;
                non_active_lat <= '0;
                remaining      <= '0;
                burst_mode     <= 1'b0;
                done_q         <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (!bus.enable[c]) begin
                    state          <= IDLE;
                    cnt            <= '0;
                    non_active_lat <= '0;
                    remaining      <= '0;
                    burst_mode     <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (!bus.mode[c] || bus.start[c]) begin
                                state          <= ACTIVE;
                                cnt            <= active_req - CNT_ONE;
                                non_active_lat <= non_active_req;
                                burst_mode     <= bus.mode[c];
                                remaining      <= bus.mode[c] ? (burst_req - BURST_ONE) : '0;
                            end
                        end
                        ACTIVE: begin
                            if (cnt == '0) begin
                                state <= NON_ACTIVE;
                                cnt   <= non_active_lat - CNT_ONE;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                        NON_ACTIVE: begin
                            if (cnt != '0) begin
                                cnt <= cnt - CNT_ONE;
                            end else if (burst_mode && (remaining == '0)) begin
                                state      <= IDLE;
                                burst_mode <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                state          <= ACTIVE;
                                cnt            <= active_req - CNT_ONE;
                                non_active_lat <= non_active_req;
                                if (burst_mode) begin
                                    remaining <= remaining - BURST_ONE;
                                end
                            end
                        end
                        default: begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end

        assign pulse_vec[c] = (state == ACTIVE);
        assign busy_vec[c]  = (state != IDLE);
        assign done_vec[c]  = done_q;
    end

endmodule
